// File: rtl/sample_feeder.sv
// Sample feeder: a small circular FIFO of 16-bit samples drained through a
// Rdy/Ack handshake, with a per-request timeout and sticky error flags.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no sample offered; waits for the FIFO to become non-empty
// REQ    | head sample on DataOut with Rdy=1; waits for Ack or timeout
// HOLD   | Rdy=0 gap; waits for Ack to drop before offering the next one
module sample_feeder #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] WrData,
    input  logic        WrEn,
    input  logic        ClrErr,
    output logic        Full,
    output logic        Empty,
    output logic [15:0] DataOut,
    output logic        Rdy,
    input  logic        Ack,
    output logic        Overflow,
    output logic        Timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
    } state_t;

    state_t        state_q;
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [15:0]   timer_q;
    logic [15:0]   data_q;
    logic          rdy_q;
    logic          full_q;
    logic          empty_q;
    logic          ovf_q;
    logic          tmo_q;

    logic pop;
    logic push;
    logic drop;
    logic expire;

    // A pop frees a slot in the same cycle, so a write into a full FIFO
    // is still accepted when the consumer acknowledges on that edge.
    always_comb begin
        pop     = (state_q == S_REQ) && Ack;
        expire  = (state_q == S_REQ) && !Ack && (timer_q == TMO_LAST);
        push    = WrEn && ((count_q != FULL_CNT) || pop);
        drop    = WrEn && !push;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Sample storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= WrData;
        end
    end

    // FIFO bookkeeping, sticky flags and the handshake FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            data_q   <= '0;
            rdy_q    <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == '0);
            // Set wins over clear when both happen on the same edge.
            ovf_q   <= drop   | (ovf_q & ~ClrErr);
            tmo_q   <= expire | (tmo_q & ~ClrErr);

            case (state_q)
                S_IDLE: begin
                    if (!empty_q) begin
                        data_q  <= mem_q[rd_ptr_q];
                        rdy_q   <= 1'b1;
                        timer_q <= '0;
                        state_q <= S_REQ;
                    end else begin
                        rdy_q <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (Ack || expire) begin
                        // On expiry the head stays in place and is re-offered.
                        rdy_q   <= 1'b0;
                        state_q <= S_HOLD;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_HOLD: begin
                    rdy_q <= 1'b0;
                    if (!Ack) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    rdy_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Full     = full_q;
    assign Empty    = empty_q;
    assign DataOut  = data_q;
    assign Rdy      = rdy_q;
    assign Overflow = ovf_q;
    assign Timeout  = tmo_q;

endmodule

// File: tb/tb_sample_feeder.sv
// Directed bench for sample_feeder (DEPTH=8, TIMEOUT=4). All activity is
// driven and observed 1 ns after the rising edge. The optional consumer
// model pulses Ack for one cycle, one cycle after it first sees Rdy.
module tb_sample_feeder;

    logic        clk;
    logic        reset;
    logic [15:0] WrData;
    logic        WrEn;
    logic        ClrErr;
    logic        Full;
    logic        Empty;
    logic [15:0] DataOut;
    logic        Rdy;
    logic        Ack;
    logic        Overflow;
    logic        Timeout;

    int errors = 0;
    int checks = 0;

    logic        auto_ack;
    logic        seen_rdy;
    logic [15:0] got[$];

    sample_feeder #(.DEPTH(8), .TIMEOUT(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .WrData   (WrData),
        .WrEn     (WrEn),
        .ClrErr   (ClrErr),
        .Full     (Full),
        .Empty    (Empty),
        .DataOut  (DataOut),
        .Rdy      (Rdy),
        .Ack      (Ack),
        .Overflow (Overflow),
        .Timeout  (Timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: log the sample popped on this edge, then update the consumer.
    task automatic tick();
        if (Rdy && Ack) got.push_back(DataOut);
        @(posedge clk);
        #1;
        if (auto_ack) Ack = seen_rdy && !Ack;
        seen_rdy = Rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1; WrEn = 1'b0; ClrErr = 1'b0; Ack = 1'b0;
        auto_ack = 1'b0; seen_rdy = 1'b0; WrData = 16'h0000;
        tick(); tick();
        reset = 1'b0;
        got.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (Rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", Rdy); end
        checks++; if (DataOut !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h exp=0000", DataOut); end
        checks++; if (Full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", Full); end
        checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", Empty); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", Overflow); end
        checks++; if (Timeout !== 1'b0) begin errors++; $display("FAIL reset_tmo got=%b exp=0", Timeout); end
    endtask

    task automatic test_single();
        do_reset();
        auto_ack = 1'b1;
        WrData = 16'h1234; WrEn = 1'b1;
        tick();                               // edge N
        WrEn = 1'b0;
        checks++; if (Empty !== 1'b0 || Rdy !== 1'b0) begin errors++; $display("FAIL single_n empty=%b rdy=%b exp empty=0 rdy=0", Empty, Rdy); end
        tick();                               // N+1
        checks++; if (Rdy !== 1'b1 || DataOut !== 16'h1234) begin errors++; $display("FAIL single_rise rdy=%b data=%h exp rdy=1 data=1234", Rdy, DataOut); end
        tick();                               // N+2
        checks++; if (Rdy !== 1'b1) begin errors++; $display("FAIL single_hold2 rdy=%b exp=1", Rdy); end
        tick();                               // N+3
        checks++; if (Rdy !== 1'b0 || Empty !== 1'b1) begin errors++; $display("FAIL single_done rdy=%b empty=%b exp rdy=0 empty=1", Rdy, Empty); end
        checks++; if (got.size() != 1 || got[0] !== 16'h1234) begin errors++; $display("FAIL single_pop count=%0d exp 1 sample 1234", got.size()); end
    endtask

    task automatic test_back_to_back();
        int rises[$];
        int high;
        logic prev;
        do_reset();
        auto_ack = 1'b1;
        high = 0; prev = 1'b0;
        for (int i = 0; i < 24; i++) begin
            WrEn = (i < 3);
            WrData = 16'(16'h0010 + i);
            tick();
            if (Rdy) high++;
            if (Rdy && !prev) rises.push_back(i);
            prev = Rdy;
        end
        WrEn = 1'b0;
        checks++; if (rises.size() != 3) begin errors++; $display("FAIL b2b_rises got=%0d exp=3", rises.size()); end
        else begin
            checks++; if (rises[0] != 1) begin errors++; $display("FAIL b2b_first got=%0d exp=1", rises[0]); end
            checks++; if (rises[1] - rises[0] != 4 || rises[2] - rises[1] != 4) begin errors++; $display("FAIL b2b_period got=%0d,%0d exp=4,4", rises[1] - rises[0], rises[2] - rises[1]); end
        end
        checks++; if (high != 6) begin errors++; $display("FAIL b2b_rdy_cycles got=%0d exp=6", high); end
        checks++; if (got.size() != 3 || got[0] !== 16'h0010 || got[1] !== 16'h0011 || got[2] !== 16'h0012) begin errors++; $display("FAIL b2b_order count=%0d exp 0010,0011,0012", got.size()); end
    endtask

    task automatic test_burst_overflow();
        int bad;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            WrData = 16'(i); WrEn = 1'b1;
            tick();
        end
        checks++; if (Full !== 1'b1 || Overflow !== 1'b0) begin errors++; $display("FAIL burst_full full=%b ovf=%b exp full=1 ovf=0", Full, Overflow); end
        WrData = 16'h0009;
        tick();
        WrEn = 1'b0;
        checks++; if (Overflow !== 1'b1 || Full !== 1'b1) begin errors++; $display("FAIL burst_ovf ovf=%b full=%b exp ovf=1 full=1", Overflow, Full); end
        auto_ack = 1'b1;
        for (int i = 0; i < 80 && !(got.size() == 8 && Empty); i++) tick();
        checks++; if (got.size() != 8 || Empty !== 1'b1) begin errors++; $display("FAIL burst_drain count=%0d empty=%b exp count=8 empty=1", got.size(), Empty); end
        bad = 0;
        for (int i = 0; i < got.size() && i < 8; i++) if (got[i] !== 16'(i + 1)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL burst_order wrong=%0d exp 0 (0001..0008)", bad); end
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset();
        WrData = 16'hBEEF; WrEn = 1'b1;
        tick();                               // N
        WrEn = 1'b0;
        tick();                               // N+1: Rdy rises
        cnt = 0;
        for (int i = 0; i < 10 && Rdy; i++) begin cnt++; tick(); end
        checks++; if (cnt != 4) begin errors++; $display("FAIL tmo_rdy_cycles got=%0d exp=4", cnt); end
        checks++; if (Timeout !== 1'b1 || Rdy !== 1'b0) begin errors++; $display("FAIL tmo_flag tmo=%b rdy=%b exp tmo=1 rdy=0", Timeout, Rdy); end
        tick();
        checks++; if (Rdy !== 1'b0) begin errors++; $display("FAIL tmo_gap rdy=%b exp=0", Rdy); end
        tick();
        checks++; if (Rdy !== 1'b1 || DataOut !== 16'hBEEF || Empty !== 1'b0) begin errors++; $display("FAIL tmo_retry rdy=%b data=%h empty=%b exp 1 beef 0", Rdy, DataOut, Empty); end
    endtask

    // Continues from test_timeout: Timeout=1 and BEEF still queued.
    task automatic test_clr_err();
        ClrErr = 1'b1;
        tick();
        ClrErr = 1'b0;
        checks++; if (Timeout !== 1'b0) begin errors++; $display("FAIL clr_tmo got=%b exp=0", Timeout); end
        for (int i = 0; i < 7; i++) begin
            WrData = 16'(16'h0B00 + i); WrEn = 1'b1;
            tick();
        end
        checks++; if (Full !== 1'b1) begin errors++; $display("FAIL clr_fill full=%b exp=1", Full); end
        tick();                               // rejected write sets Overflow
        ClrErr = 1'b1;
        tick();                               // rejected write plus clear
        WrEn = 1'b0;
        checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL clr_set_wins ovf=%b exp=1", Overflow); end
        tick();                               // clear alone
        ClrErr = 1'b0;
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf ovf=%b exp=0", Overflow); end
    endtask

    task automatic test_full_pop();
        logic found;
        int bad;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            WrData = 16'(16'hA000 + i); WrEn = 1'b1;
            tick();
        end
        WrEn = 1'b0;
        auto_ack = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (Rdy && Ack) begin
                WrData = 16'hA009; WrEn = 1'b1;
                tick();
                WrEn = 1'b0;
                found = 1'b1;
            end else begin
                tick();
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL fullpop_ack_seen got=0 exp=1"); end
        checks++; if (Full !== 1'b1 || Overflow !== 1'b0) begin errors++; $display("FAIL fullpop_flags full=%b ovf=%b exp full=1 ovf=0", Full, Overflow); end
        for (int i = 0; i < 80 && got.size() < 9; i++) tick();
        bad = 0;
        for (int i = 0; i < got.size() && i < 9; i++) if (got[i] !== 16'(16'hA001 + i)) bad++;
        checks++; if (got.size() != 9 || bad != 0) begin errors++; $display("FAIL fullpop_order count=%0d wrong=%0d exp count=9 wrong=0", got.size(), bad); end
    endtask

    task automatic test_reset_mid();
        int rdy_seen;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            WrData = 16'(16'h0C00 + i); WrEn = 1'b1;
            tick();
        end
        WrEn = 1'b0;
        checks++; if (Rdy !== 1'b1) begin errors++; $display("FAIL mid_in_req rdy=%b exp=1", Rdy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (Rdy !== 1'b0 || Empty !== 1'b1 || Overflow !== 1'b0 || Timeout !== 1'b0) begin errors++; $display("FAIL mid_reset rdy=%b empty=%b ovf=%b tmo=%b exp 0 1 0 0", Rdy, Empty, Overflow, Timeout); end
        rdy_seen = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (Rdy) rdy_seen++; end
        checks++; if (rdy_seen != 0) begin errors++; $display("FAIL mid_quiet rdy_cycles=%0d exp=0", rdy_seen); end
        WrData = 16'hC0DE; WrEn = 1'b1;
        tick();
        WrEn = 1'b0;
        tick();
        checks++; if (Rdy !== 1'b1 || DataOut !== 16'hC0DE) begin errors++; $display("FAIL mid_new rdy=%b data=%h exp 1 c0de", Rdy, DataOut); end
    endtask

    initial begin
        reset = 1'b1; WrEn = 1'b0; ClrErr = 1'b0; Ack = 1'b0;
        WrData = 16'h0000; auto_ack = 1'b0; seen_rdy = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_burst_overflow();
        test_timeout();
        test_clr_err();
        test_full_pop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
